// File: rtl/guess_pkg.sv
// Shared definitions for the guessing-game player and referee.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: referee feedback codes and the player FSM state encoding.
package guess_pkg;

  // Referee feedback codes carried on fb_code.
  localparam logic [1:0] FB_NONE = 2'b00;  // no feedback this cycle
  localparam logic [1:0] FB_LOW  = 2'b01;  // guess too low, target is greater
  localparam logic [1:0] FB_HIGH = 2'b10;  // guess too high, target is smaller
  localparam logic [1:0] FB_HIT  = 2'b11;  // guess equals target

  // Player FSM state encoding, shared with the referee for debug visibility.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CALC    = 3'd1;
  localparam logic [2:0] ST_PROPOSE = 3'd2;
  localparam logic [2:0] ST_FOUND   = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;

endpackage

// File: rtl/guess_player_if.sv
// Player <-> referee link: start strobe, feedback strobe/code, guess and status.
// Latency: n/a (wires only).
// Backpressure: none; the player holds guess_valid until feedback arrives.
// master = player side (drives guess/status), slave = referee/controller side.
interface guess_player_if #(
  parameter int W     = 8,
  parameter int CNT_W = 4
);
  import guess_pkg::*;

  logic             start;
  logic             fb_valid;
  logic [1:0]       fb_code;
  logic [W-1:0]     guess;
  logic             guess_valid;
  logic             found;
  logic             fail;
  logic [CNT_W-1:0] tries;

  modport master (
    input  start, fb_valid, fb_code,
    output guess, guess_valid, found, fail, tries
  );

  modport slave (
    output start, fb_valid, fb_code,
    input  guess, guess_valid, found, fail, tries
  );

endinterface

// File: rtl/guess_player.sv
// Binary-search player: proposes floor-midpoint guesses and narrows [lo,hi] from referee feedback.
// Latency: start -> first guess_valid 2 cycles; accepted feedback -> next guess_valid 2 cycles.
// Backpressure: guess is held with guess_valid high until a non-none feedback strobe; no stall upstream.
// Ports: clk, reset (sync, active-high); bus (master): start, fb_valid, fb_code in;
//        guess, guess_valid, found, fail, tries out. W/CNT_W must match the interface instance.
module guess_player
  import guess_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_TRIES = 9,
  parameter int CNT_W     = 4
) (
  input  logic           clk,
  input  logic           reset,
  guess_player_if.master bus
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic [2:0]       state;
  logic [W-1:0]     lo;
  logic [W-1:0]     hi;
  logic [W-1:0]     guess_q;
  logic [CNT_W-1:0] tries_q;
  logic             found_q;
  logic             fail_q;

  // Midpoint via a W+1-bit sum so lo+hi never wraps.
  logic [W:0]   sum;
  logic [W-1:0] mid;
  logic [W-1:0] lo_next;
  logic [W-1:0] hi_next;
  logic         at_max;

  assign sum     = {1'b0, lo} + {1'b0, hi};
  assign mid     = sum[W:1];
  assign lo_next = guess_q + W'(1);
  assign hi_next = guess_q - W'(1);
  assign at_max  = (tries_q == CNT_W'(MAX_TRIES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      lo      <= '0;
      hi      <= ALL_ONES;
      guess_q <= '0;
      tries_q <= '0;
      found_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_FOUND, ST_FAIL: begin
          if (bus.start) begin
            lo      <= '0;
            hi      <= ALL_ONES;
            tries_q <= '0;
            found_q <= 1'b0;
            fail_q  <= 1'b0;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          guess_q <= mid;
          tries_q <= tries_q + CNT_W'(1);
          state   <= ST_PROPOSE;
        end
        ST_PROPOSE: begin
          if (bus.fb_valid) begin
            case (bus.fb_code)
              FB_HIT: begin
                found_q <= 1'b1;
                state   <= ST_FOUND;
              end
              FB_LOW: begin
                // Target above the top value is a contradiction; do not wrap lo.
                if (guess_q == ALL_ONES) begin
                  fail_q <= 1'b1;
                  state  <= ST_FAIL;
                end else begin
                  lo <= lo_next;
                  if (lo_next > hi || at_max) begin
                    fail_q <= 1'b1;
                    state  <= ST_FAIL;
                  end else begin
                    state <= ST_CALC;
                  end
                end
              end
              FB_HIGH: begin
                // Target below zero is a contradiction; do not wrap hi.
                if (guess_q == '0) begin
                  fail_q <= 1'b1;
                  state  <= ST_FAIL;
                end else begin
                  hi <= hi_next;
                  if (lo > hi_next || at_max) begin
                    fail_q <= 1'b1;
                    state  <= ST_FAIL;
                  end else begin
                    state <= ST_CALC;
                  end
                end
              end
              default: ;  // FB_NONE: keep waiting
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.guess       = guess_q;
  assign bus.guess_valid = (state == ST_PROPOSE);
  assign bus.found       = found_q;
  assign bus.fail        = fail_q;
  assign bus.tries       = tries_q;

endmodule

// File: tb/tb_guess_player.sv
// Bench for guess_player: table of full searches, randomized targets against an
// interval-halving reference, and hand-written corner sequences.
// Clock period 10; stimulus driven and outputs sampled 1 time unit after posedge.
module tb_guess_player;
  import guess_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  guess_player_if #(.W(8), .CNT_W(4)) bus_a ();
  guess_player_if #(.W(8), .CNT_W(4)) bus_b ();

  guess_player #(.W(8), .MAX_TRIES(9), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.master)
  );
  guess_player #(.W(8), .MAX_TRIES(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.master)
  );

  int nvec = 0;
  int nmis = 0;

  // Reference of the search interval, kept as plain integers.
  int m_lo, m_hi, m_tries, m_max;
  bit m_done, m_found, m_fail;

  typedef struct {
    logic [7:0] target;
    int         mode;       // 0 truthful referee, 1 always "too high", 2 always "too low"
    logic       exp_found;
    logic       exp_fail;
    logic [3:0] exp_tries;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called after the edge that sampled start/feedback; guess_valid must rise on the 2nd edge.
  task automatic wait_gv(input string name);
    int n = 1;
    while (!bus_a.guess_valid && n < 8) begin
      cyc();
      n++;
    end
    check(name, n, 2);
    if (!bus_a.guess_valid) m_done = 1'b1;
  endtask

  task automatic start_search();
    bus_a.start = 1'b1;
    cyc();
    bus_a.start = 1'b0;
    m_lo = 0; m_hi = 255; m_tries = 0; m_max = 9;
    m_done = 1'b0; m_found = 1'b0; m_fail = 1'b0;
    check("start_clears", {bus_a.found, bus_a.fail, bus_a.guess_valid}, 0);
    wait_gv("start_latency");
  endtask

  task automatic respond(input int mode, input int target);
    int g;
    logic [1:0] code;
    g = (m_lo + m_hi) / 2;
    m_tries++;
    check("guess", bus_a.guess, g);
    check("tries", bus_a.tries, m_tries);
    if (mode == 1)      code = FB_HIGH;
    else if (mode == 2) code = FB_LOW;
    else if (target > g) code = FB_LOW;
    else if (target < g) code = FB_HIGH;
    else                 code = FB_HIT;
    bus_a.fb_valid = 1'b1;
    bus_a.fb_code  = code;
    cyc();
    bus_a.fb_valid = 1'b0;
    bus_a.fb_code  = FB_NONE;
    check("gv_drop", bus_a.guess_valid, 0);
    if (code == FB_HIT) begin
      m_done = 1'b1; m_found = 1'b1;
    end else if (code == FB_LOW) begin
      if (g == 255) begin
        m_done = 1'b1; m_fail = 1'b1;
      end else begin
        m_lo = g + 1;
        if (m_lo > m_hi || m_tries == m_max) begin m_done = 1'b1; m_fail = 1'b1; end
      end
    end else begin
      if (g == 0) begin
        m_done = 1'b1; m_fail = 1'b1;
      end else begin
        m_hi = g - 1;
        if (m_lo > m_hi || m_tries == m_max) begin m_done = 1'b1; m_fail = 1'b1; end
      end
    end
    if (!m_done) wait_gv("fb_latency");
  endtask

  task automatic finish_search(input int mode, input int target);
    int k = 0;
    while (!m_done && k < 12) begin
      respond(mode, target);
      k++;
    end
    check("end_found", bus_a.found, m_found);
    check("end_fail", bus_a.fail, m_fail);
  endtask

  task automatic play(input int mode, input int target);
    start_search();
    finish_search(mode, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd9,   0, 1'b1, 1'b0, 4'd7};
    vecs[1] = '{8'd255, 0, 1'b1, 1'b0, 4'd9};
    vecs[2] = '{8'd0,   0, 1'b1, 1'b0, 4'd8};
    vecs[3] = '{8'd127, 0, 1'b1, 1'b0, 4'd1};
    vecs[4] = '{8'd128, 0, 1'b1, 1'b0, 4'd8};
    vecs[5] = '{8'd9,   1, 1'b0, 1'b1, 4'd8};
    vecs[6] = '{8'd9,   2, 1'b0, 1'b1, 4'd9};

    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.fb_valid = 1'b0; bus_a.fb_code = FB_NONE;
    bus_b.start = 1'b0; bus_b.fb_valid = 1'b0; bus_b.fb_code = FB_NONE;
    cyc();
    cyc();
    reset = 1'b0;
    check("reset_a", {bus_a.guess, bus_a.guess_valid, bus_a.found, bus_a.fail, bus_a.tries}, 0);
    check("reset_b", {bus_b.guess, bus_b.guess_valid, bus_b.found, bus_b.fail, bus_b.tries}, 0);

    // Table of complete searches.
    for (int i = 0; i < 7; i++) begin
      play(vecs[i].mode, vecs[i].target);
      check("tbl_found", bus_a.found, vecs[i].exp_found);
      check("tbl_fail", bus_a.fail, vecs[i].exp_fail);
      check("tbl_tries", bus_a.tries, vecs[i].exp_tries);
      if (vecs[i].exp_found) check("tbl_guess", bus_a.guess, vecs[i].target);
    end

    // Randomized targets: every target must be found within W+1 guesses.
    for (int i = 0; i < 24; i++) begin
      int t;
      t = $urandom_range(0, 255);
      play(0, t);
      check("rnd_found", bus_a.found, 1);
      check("rnd_guess", bus_a.guess, t);
      check("rnd_tries_bound", (bus_a.tries <= 4'd9), 1);
    end

    // Ignored inputs: none-code strobe, start in PROPOSE, feedback during CALC.
    start_search();
    bus_a.fb_valid = 1'b1; bus_a.fb_code = FB_NONE;
    cyc();
    bus_a.fb_valid = 1'b0;
    check("ign_none_gv", bus_a.guess_valid, 1);
    check("ign_none_guess", bus_a.guess, 127);
    check("ign_none_tries", bus_a.tries, 1);
    bus_a.start = 1'b1;
    cyc();
    bus_a.start = 1'b0;
    check("ign_start_gv", bus_a.guess_valid, 1);
    check("ign_start_guess", bus_a.guess, 127);
    check("ign_start_tries", bus_a.tries, 1);
    bus_a.fb_valid = 1'b1; bus_a.fb_code = FB_HIGH;
    cyc();
    bus_a.fb_code = FB_HIT;   // still strobing while the player is in CALC
    cyc();
    bus_a.fb_valid = 1'b0; bus_a.fb_code = FB_NONE;
    check("ign_calc_gv", bus_a.guess_valid, 1);
    check("ign_calc_guess", bus_a.guess, 63);
    check("ign_calc_tries", bus_a.tries, 2);
    check("ign_calc_found", bus_a.found, 0);
    m_lo = 0; m_hi = 126; m_tries = 1;
    finish_search(0, 9);
    check("ign_tail_tries", bus_a.tries, 7);

    // Try budget of 4 on the second instance.
    begin
      int lo_b = 0;
      int hi_b = 255;
      int g;
      int extra = 0;
      bus_b.start = 1'b1;
      cyc();
      bus_b.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int n = 0;
        while (!bus_b.guess_valid && n < 6) begin cyc(); n++; end
        check("b_gv", bus_b.guess_valid, 1);
        g = (lo_b + hi_b) / 2;
        check("b_guess", bus_b.guess, g);
        check("b_tries", bus_b.tries, k + 1);
        hi_b = g - 1;
        bus_b.fb_valid = 1'b1; bus_b.fb_code = FB_HIGH;
        cyc();
        bus_b.fb_valid = 1'b0; bus_b.fb_code = FB_NONE;
      end
      check("b_fail", bus_b.fail, 1);
      check("b_found", bus_b.found, 0);
      check("b_tries_end", bus_b.tries, 4);
      for (int k = 0; k < 5; k++) begin
        cyc();
        if (bus_b.guess_valid) extra++;
      end
      check("b_no_5th_guess", extra, 0);
      check("b_fail_sticky", bus_b.fail, 1);
    end

    // Reset during the third guess, then a clean restart.
    start_search();
    respond(0, 9);
    respond(0, 9);
    check("pre_reset_guess", bus_a.guess, 31);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midreset_outs", {bus_a.guess, bus_a.guess_valid, bus_a.found, bus_a.fail, bus_a.tries}, 0);
    cyc();
    cyc();
    check("midreset_idle", bus_a.guess_valid, 0);
    play(0, 9);
    check("restart_found", bus_a.found, 1);
    check("restart_tries", bus_a.tries, 7);

    // Reset and start on the same edge: reset wins, player stays idle.
    reset = 1'b1; bus_a.start = 1'b1;
    cyc();
    reset = 1'b0; bus_a.start = 1'b0;
    cyc();
    cyc();
    check("rst_start_outs", {bus_a.guess_valid, bus_a.found, bus_a.fail, bus_a.tries}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
